// File: rtl/cmd_cfg_unit.sv
// Command/configuration unit: decodes host commands into flight setpoints and
// sequences the ESC spin-up and inertial calibration handshake.
module cmd_cfg_unit #(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic        inertial_cal,
  output logic        motors_off,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst
);

  localparam int TW = (FAST_SIM != 0) ? 9 : 26;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MTR_WAIT = 2'd1,
    CAL_WAIT = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0]   d_ptch_q, d_ptch_d;
  logic [15:0]   d_roll_q, d_roll_d;
  logic [15:0]   d_yaw_q, d_yaw_d;
  logic [8:0]    thrst_q, thrst_d;
  logic          motors_off_q, motors_off_d;
  logic          inertial_cal_q, inertial_cal_d;
  logic          clr_cmd_rdy_q, clr_cmd_rdy_d;
  logic          send_resp_q, send_resp_d;
  logic          strt_cal_q, strt_cal_d;
  logic          accept_s;
  logic          tmr_full_s;

  // A command still being consumed (clr pulse in flight) is not taken twice.
  assign accept_s   = (state_q == IDLE) && cmd_rdy && !clr_cmd_rdy_q;
  assign tmr_full_s = &tmr_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tmr_q          <= '0;
      d_ptch_q       <= 16'h0000;
      d_roll_q       <= 16'h0000;
      d_yaw_q        <= 16'h0000;
      thrst_q        <= 9'h000;
      motors_off_q   <= 1'b1;
      inertial_cal_q <= 1'b0;
      clr_cmd_rdy_q  <= 1'b0;
      send_resp_q    <= 1'b0;
      strt_cal_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      d_ptch_q       <= d_ptch_d;
      d_roll_q       <= d_roll_d;
      d_yaw_q        <= d_yaw_d;
      thrst_q        <= thrst_d;
      motors_off_q   <= motors_off_d;
      inertial_cal_q <= inertial_cal_d;
      clr_cmd_rdy_q  <= clr_cmd_rdy_d;
      send_resp_q    <= send_resp_d;
      strt_cal_q     <= strt_cal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (cmd)
            SET_PTCH, SET_ROLL, SET_YAW, SET_THRST,
            EMER_LAND, MTRS_OFF: state_d = ACK;
            CALIBRATE:           state_d = MTR_WAIT;
            default:             state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      MTR_WAIT: begin
        if (tmr_full_s) begin
          state_d = CAL_WAIT;
        end else begin
          state_d = MTR_WAIT;
        end
      end
      CAL_WAIT: begin
        if (cal_done) begin
          state_d = IDLE;
        end else begin
          state_d = CAL_WAIT;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    tmr_d          = tmr_q;
    d_ptch_d       = d_ptch_q;
    d_roll_d       = d_roll_q;
    d_yaw_d        = d_yaw_q;
    thrst_d        = thrst_q;
    motors_off_d   = motors_off_q;
    inertial_cal_d = inertial_cal_q;
    clr_cmd_rdy_d  = 1'b0;
    send_resp_d    = 1'b0;
    strt_cal_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          clr_cmd_rdy_d = 1'b1;
          case (cmd)
            SET_PTCH:  d_ptch_d = data;
            SET_ROLL:  d_roll_d = data;
            SET_YAW:   d_yaw_d  = data;
            SET_THRST: thrst_d  = data[8:0];
            EMER_LAND: begin
              d_ptch_d = 16'h0000;
              d_roll_d = 16'h0000;
              d_yaw_d  = 16'h0000;
              thrst_d  = 9'h000;
            end
            MTRS_OFF:  motors_off_d = 1'b1;
            CALIBRATE: begin
              motors_off_d = 1'b0;
              tmr_d        = '0;
            end
            default: clr_cmd_rdy_d = 1'b1;
          endcase
        end else begin
          clr_cmd_rdy_d = 1'b0;
        end
      end
      MTR_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_full_s) begin
          strt_cal_d     = 1'b1;
          inertial_cal_d = 1'b1;
        end else begin
          strt_cal_d     = 1'b0;
        end
      end
      CAL_WAIT: begin
        // inertial_cal drops on the same edge that raises send_resp.
        if (cal_done) begin
          send_resp_d    = 1'b1;
          inertial_cal_d = 1'b0;
        end else begin
          inertial_cal_d = 1'b1;
        end
      end
      ACK:     send_resp_d = 1'b1;
      default: send_resp_d = 1'b0;
    endcase
  end

  assign clr_cmd_rdy  = clr_cmd_rdy_q;
  assign send_resp    = send_resp_q;
  assign strt_cal     = strt_cal_q;
  assign inertial_cal = inertial_cal_q;
  assign motors_off   = motors_off_q;
  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign resp         = ACK_BYTE;

endmodule

// File: doc/cmd_cfg_unit.md
CMD_CFG_UNIT -- requirements
Module: cmd_cfg_unit

Interface
REQ-001 Parameter: FAST_SIM, default 1, selects the ESC spin-up timer width: 9 bits when 1, 26 bits when 0.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 cmd_rdy  in  1  a complete host command and its data are valid.
REQ-006 cmd  in  8  command opcode.
REQ-007 data  in  16  command payload.
REQ-008 clr_cmd_rdy  out  1  one-cycle pulse that consumes the current command.
REQ-009 resp  out  8  response byte; constant 8'hA5 (ACK).
REQ-010 send_resp  out  1  one-cycle pulse requesting transmission of resp.
REQ-011 cal_done  in  1  inertial calibration complete (pulse).
REQ-012 strt_cal  out  1  one-cycle pulse that starts inertial calibration.
REQ-013 inertial_cal  out  1  high while calibration is in progress.
REQ-014 motors_off  out  1  forces the ESC outputs to idle.
REQ-015 d_ptch  out  16  desired pitch.
REQ-016 d_roll  out  16  desired roll.
REQ-017 d_yaw  out  16  desired yaw.
REQ-018 thrst  out  9  desired thrust.

Function
REQ-019 Opcodes are: 02 SET_PTCH, 03 SET_ROLL, 04 SET_YAW, 05 SET_THRST, 06 CALIBRATE, 07 EMER_LAND, 08 MTRS_OFF.
REQ-020 The FSM states are IDLE, MTR_WAIT, CAL_WAIT and ACK.
REQ-021 Commands are accepted only in IDLE with cmd_rdy high; clr_cmd_rdy pulses in the acceptance cycle.
REQ-022 SET_PTCH, SET_ROLL and SET_YAW load data[15:0] into d_ptch, d_roll or d_yaw respectively on the acceptance edge.
REQ-023 SET_THRST loads data[8:0] into thrst on the acceptance edge; data[15:9] is ignored.
REQ-024 For set commands, send_resp pulses on the cycle after acceptance; the next state is IDLE.
REQ-025 EMER_LAND clears d_ptch, d_roll, d_yaw and thrst to 0 on the acceptance edge; it then ACKs as a set command and motors_off is unchanged.
REQ-026 MTRS_OFF sets motors_off to 1 on the acceptance edge and ACKs; the setpoint registers are unchanged.
REQ-027 CALIBRATE clears motors_off, clears the spin-up timer and enters MTR_WAIT.
REQ-028 MTR_WAIT: the timer increments each clock; when it reaches all-ones, the FSM pulses strt_cal for one cycle and enters CAL_WAIT.
REQ-029 The MTR_WAIT duration is 2^9 clocks with FAST_SIM=1 and 2^26 clocks with FAST_SIM=0.
REQ-030 CAL_WAIT: inertial_cal is held high; on cal_done the FSM pulses send_resp on the next cycle and returns to IDLE.
REQ-031 inertial_cal deasserts in the same cycle that send_resp asserts.
REQ-032 An unrecognized opcode is consumed with a clr_cmd_rdy pulse and produces no response and no register change.
REQ-033 cmd_rdy is ignored while in MTR_WAIT, CAL_WAIT or ACK; a pending command is taken on the first IDLE cycle after the FSM returns.
REQ-034 cal_done is ignored outside CAL_WAIT.
REQ-035 A CALIBRATE received while motors_off=0 restarts the full spin-up and calibration sequence.
REQ-036 Each response-producing command yields exactly one send_resp pulse; no pulse is ever extended or repeated.
REQ-037 clr_cmd_rdy, send_resp and strt_cal are registered outputs.

Reset
REQ-038 While rst is high, and on its assertion asynchronously: FSM=IDLE, timer=0, d_ptch=d_roll=d_yaw=0, thrst=0, motors_off=1, inertial_cal=0, all pulse outputs=0, resp=8'hA5.
REQ-039 Reset asserted mid-calibration aborts the sequence: no strt_cal and no send_resp is emitted afterward.
REQ-040 The first command can be accepted on the first clock edge after rst deasserts.

Verification
REQ-041 After reset, CALIBRATE with FAST_SIM=1 -> motors_off falls the next cycle; strt_cal pulses 512 clocks later; cal_done returned 100 clocks after that -> one send_resp pulse with resp=A5.
REQ-042 SET_THRST data=16'hFFFF -> thrst=9'h1FF, one ACK; then SET_PTCH data=16'h0100 -> d_ptch=16'h0100, other setpoints unchanged.
REQ-043 Set d_roll=16'hFF80 and d_yaw=16'h0080, then EMER_LAND -> all four setpoints are 0, motors_off stays 0, one ACK.
REQ-044 MTRS_OFF -> motors_off=1 and setpoints retained; then opcode 8'h3C -> clr_cmd_rdy pulses, no send_resp within 20 clocks.
REQ-045 cmd_rdy with SET_YAW held during CAL_WAIT -> it is not accepted until after the calibration ACK, then d_yaw updates and a second ACK follows.
REQ-046 Assert rst 200 clocks into MTR_WAIT -> all outputs return to reset values; no strt_cal is seen for 1000 clocks after release.
